// File: rtl/extended_hamming_scrubber.sv
// Background scrubber for extended-Hamming protected memory: read, correct, re-check, write back.
// Define EXTENDED_HAMMING_SCRUBBER_WRITEBACK_EN to write corrected blocks back; otherwise report-only.

// Codeword layout: bit i (i < W-1) is Hamming position i+1, bit W-1 is overall parity.
module extended_hamming_block_corrector #(
    parameter int BLOCK_WIDTH = 13
) (
    input  logic [BLOCK_WIDTH-1:0] block_in,
    output logic [BLOCK_WIDTH-1:0] block_out,
    output logic                   error
);
    localparam int SW = $clog2(BLOCK_WIDTH);

    logic [SW-1:0] syndrome;
    logic          overall;

    always_comb begin
        syndrome = '0;
        for (int p = 1; p < BLOCK_WIDTH; p++)
            if (block_in[p-1]) syndrome = syndrome ^ SW'(p);
        overall   = ^block_in;
        block_out = block_in;
        // Odd overall parity means a single flip: syndrome names it, zero means the parity bit.
        if (overall && syndrome == '0)
            block_out[BLOCK_WIDTH-1] = ~block_in[BLOCK_WIDTH-1];
        for (int p = 1; p < BLOCK_WIDTH; p++)
            if (overall && syndrome == SW'(p)) block_out[p-1] = ~block_in[p-1];
        error = overall | (syndrome != '0);
    end
endmodule

module extended_hamming_block_checker #(
    parameter int BLOCK_WIDTH = 13
) (
    input  logic [BLOCK_WIDTH-1:0] block_in,
    output logic                   clean
);
    localparam int SW = $clog2(BLOCK_WIDTH);

    logic [SW-1:0] syndrome;

    always_comb begin
        syndrome = '0;
        for (int p = 1; p < BLOCK_WIDTH; p++)
            if (block_in[p-1]) syndrome = syndrome ^ SW'(p);
        clean = (syndrome == '0) && !(^block_in);
    end
endmodule

module extended_hamming_scrubber #(
    parameter  int BLOCK_WIDTH   = 13,
    parameter  int DEPTH         = 256,
    parameter  int INTERVAL      = 1024,
    parameter  int COUNTER_WIDTH = 16,
    localparam int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     clear_counters,
    output logic                     scrub_request,
    input  logic                     scrub_grant,
    output logic                     scrub_write,
    output logic [ADDRESS_WIDTH-1:0] scrub_address,
    output logic [BLOCK_WIDTH-1:0]   scrub_write_block,
    input  logic [BLOCK_WIDTH-1:0]   scrub_read_block,
    output logic                     busy,
    output logic                     error_valid,
    output logic                     error_uncorrectable,
    output logic [ADDRESS_WIDTH-1:0] error_address,
    output logic                     pass_done,
    output logic [COUNTER_WIDTH-1:0] corrected_count,
    output logic [COUNTER_WIDTH-1:0] uncorrectable_count
);
    localparam int IW = $clog2(INTERVAL + 1);
    localparam logic [IW-1:0] RELOAD = IW'(INTERVAL - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, CHECK, WRITE_REQ} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            interval_q, interval_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [BLOCK_WIDTH-1:0]   block_q, block_d;
    logic                     error_valid_q, error_valid_d;
    logic                     error_unc_q, error_unc_d;
    logic [ADDRESS_WIDTH-1:0] error_address_q, error_address_d;
    logic                     pass_done_q, pass_done_d;
    logic [COUNTER_WIDTH-1:0] corrected_q, corrected_d;
    logic [COUNTER_WIDTH-1:0] uncorrectable_q, uncorrectable_d;

    logic [BLOCK_WIDTH-1:0] corrected_block;
    logic                   corr_error, recheck_clean;
    logic                   advance, corr_inc, unc_inc;

    extended_hamming_block_corrector #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_corrector (
        .block_in (block_q),
        .block_out(corrected_block),
        .error    (corr_error)
    );

    extended_hamming_block_checker #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_checker (
        .block_in(corrected_block),
        .clean   (recheck_clean)
    );

    always_comb begin
        state_d         = state_q;
        interval_d      = interval_q;
        address_d       = address_q;
        block_d         = block_q;
        error_valid_d   = 1'b0;
        error_unc_d     = 1'b0;
        error_address_d = error_address_q;
        pass_done_d     = 1'b0;
        advance         = 1'b0;
        corr_inc        = 1'b0;
        unc_inc         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start || (enable && interval_q == '0)) begin
                    state_d    = READ_REQ;
                    interval_d = RELOAD;
                end else if (enable) begin
                    interval_d = interval_q - IW'(1);
                end
            end
            READ_REQ:  if (scrub_grant) state_d = READ_WAIT;
            READ_WAIT: begin
                block_d = scrub_read_block;
                state_d = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
                if (!corr_error) begin
                    advance = 1'b1;
                end else begin
                    error_valid_d   = 1'b1;
                    error_address_d = address_q;
                    if (recheck_clean) begin
                        corr_inc = 1'b1;
                        block_d  = corrected_block;
`ifdef EXTENDED_HAMMING_SCRUBBER_WRITEBACK_EN
                        state_d  = WRITE_REQ;
`else
                        advance  = 1'b1;
`endif
                    end else begin
                        error_unc_d = 1'b1;
                        unc_inc     = 1'b1;
                        advance     = 1'b1;
                    end
                end
            end
            WRITE_REQ: begin
                if (scrub_grant) begin
                    advance = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            address_d   = (address_q == LAST) ? '0 : address_q + ADDRESS_WIDTH'(1);
            pass_done_d = (address_q == LAST);
        end

        // A clear wins over an increment landing in the same cycle.
        corrected_d = corrected_q;
        if (clear_counters) corrected_d = '0;
        else if (corr_inc && corrected_q != '1) corrected_d = corrected_q + COUNTER_WIDTH'(1);

        uncorrectable_d = uncorrectable_q;
        if (clear_counters) uncorrectable_d = '0;
        else if (unc_inc && uncorrectable_q != '1) uncorrectable_d = uncorrectable_q + COUNTER_WIDTH'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            interval_q      <= RELOAD;
            address_q       <= '0;
            block_q         <= '0;
            error_valid_q   <= 1'b0;
            error_unc_q     <= 1'b0;
            error_address_q <= '0;
            pass_done_q     <= 1'b0;
            corrected_q     <= '0;
            uncorrectable_q <= '0;
        end else begin
            state_q         <= state_d;
            interval_q      <= interval_d;
            address_q       <= address_d;
            block_q         <= block_d;
            error_valid_q   <= error_valid_d;
            error_unc_q     <= error_unc_d;
            error_address_q <= error_address_d;
            pass_done_q     <= pass_done_d;
            corrected_q     <= corrected_d;
            uncorrectable_q <= uncorrectable_d;
        end
    end

    // Request comes straight from the state register, so grant never feeds back into it.
    assign scrub_request = (state_q == READ_REQ) || (state_q == WRITE_REQ);
    assign scrub_address = address_q;
`ifdef EXTENDED_HAMMING_SCRUBBER_WRITEBACK_EN
    assign scrub_write       = (state_q == WRITE_REQ);
    assign scrub_write_block = (state_q == WRITE_REQ) ? block_q : '0;
`else
    assign scrub_write       = 1'b0;
    assign scrub_write_block = '0;
`endif
    assign busy                = (state_q != IDLE);
    assign error_valid         = error_valid_q;
    assign error_uncorrectable = error_unc_q;
    assign error_address       = error_address_q;
    assign pass_done           = pass_done_q;
    assign corrected_count     = corrected_q;
    assign uncorrectable_count = uncorrectable_q;
endmodule

// File: tb/tb_extended_hamming_scrubber.sv
// Bench for extended_hamming_scrubber: memory model plus a transaction-level scrub model
// (brute-force single-flip decoding) compared every cycle, with directed phases on top.
module tb_extended_hamming_scrubber;
    localparam int BW = 13, DEPTH = 16, AW = 4, INTERVAL = 4, CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef EXTENDED_HAMMING_SCRUBBER_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, enable, start, clear_counters, scrub_grant;
    logic scrub_request, scrub_write, busy, error_valid, error_uncorrectable, pass_done;
    logic [AW-1:0] scrub_address, error_address;
    logic [BW-1:0] scrub_write_block, scrub_read_block;
    logic [CW-1:0] corrected_count, uncorrectable_count;

    logic [BW-1:0] mem [DEPTH];
    int n_chk = 0, n_pass = 0, cyc = 0;

    // model state
    int m_addr, m_corr, m_unc, ev_due, pd_due, inc_due, wr_addr, last_rd;
    bit inc_unc, ev_unc, clr_prev, wr_pend;
    int ev_addr;
    logic [BW-1:0] wr_data;
    int n_reads = 0, n_pass_done = 0;
    int rd_cyc[$];
    int ev_log_addr[$];
    bit ev_log_unc[$];

    extended_hamming_scrubber #(
        .BLOCK_WIDTH(BW), .DEPTH(DEPTH), .INTERVAL(INTERVAL), .COUNTER_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .clear_counters(clear_counters), .scrub_request(scrub_request),
        .scrub_grant(scrub_grant), .scrub_write(scrub_write),
        .scrub_address(scrub_address), .scrub_write_block(scrub_write_block),
        .scrub_read_block(scrub_read_block), .busy(busy), .error_valid(error_valid),
        .error_uncorrectable(error_uncorrectable), .error_address(error_address),
        .pass_done(pass_done), .corrected_count(corrected_count),
        .uncorrectable_count(uncorrectable_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        int k;
        logic x;
        c = '0;
        k = 0;
        for (int p = 3; p <= 12; p++)
            if ((p & (p - 1)) != 0) begin c[p-1] = d[k]; k++; end
        for (int b = 0; b < 4; b++) begin
            x = 1'b0;
            for (int p = 1; p <= 12; p++) if (((p >> b) & 1) != 0) x ^= c[p-1];
            c[(1 << b) - 1] = x;
        end
        c[12] = ^c[11:0];
        return c;
    endfunction

    function automatic logic [7:0] dat(input logic [12:0] c);
        logic [7:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 3; p <= 12; p++)
            if ((p & (p - 1)) != 0) begin d[k] = c[p-1]; k++; end
        return d;
    endfunction

    // kind: 0 = valid codeword, 1 = one flip from a codeword, 2 = neither
    task automatic decode(input logic [12:0] c, output int kind, output logic [12:0] fixed);
        logic [12:0] t;
        kind  = 2;
        fixed = c;
        if (enc(dat(c)) == c) begin
            kind = 0;
        end else begin
            for (int i = 0; i < 13; i++) begin
                t = c ^ (13'(1) << i);
                if (kind == 2 && enc(dat(t)) == t) begin kind = 1; fixed = t; end
            end
        end
    endtask

    task automatic advance(input int due);
        if (m_addr == DEPTH - 1) pd_due = due;
        m_addr = (m_addr + 1) % DEPTH;
    endtask

    task automatic memory();
        forever begin
            @(posedge clock);
            if (scrub_request && scrub_grant) begin
                if (scrub_write) mem[scrub_address] <= scrub_write_block;
                else scrub_read_block <= mem[scrub_address];
            end
        end
    endtask

    task automatic monitor();
        int kind;
        logic [12:0] fixed;
        bit exp_wr;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                m_addr = 0; m_corr = 0; m_unc = 0; ev_due = -1; pd_due = -1; inc_due = -1;
                clr_prev = 0; wr_pend = 0; last_rd = -10;
                chk("reset_request", scrub_request, 0);
                chk("reset_busy", busy, 0);
            end else begin
                if (clr_prev) begin m_corr = 0; m_unc = 0; end
                else if (inc_due == cyc) begin
                    if (inc_unc) m_unc = (m_unc < CMAX) ? m_unc + 1 : m_unc;
                    else         m_corr = (m_corr < CMAX) ? m_corr + 1 : m_corr;
                end
                clr_prev = clear_counters;
                chk("corrected_count", corrected_count, m_corr);
                chk("uncorrectable_count", uncorrectable_count, m_unc);
                chk("error_valid", error_valid, ev_due == cyc);
                if (ev_due == cyc) begin
                    chk("error_uncorrectable", error_uncorrectable, ev_unc);
                    chk("error_address", error_address, ev_addr);
                    ev_log_addr.push_back(ev_addr);
                    ev_log_unc.push_back(ev_unc);
                end
                chk("pass_done", pass_done, pd_due == cyc);
                if (pass_done) n_pass_done++;
                if (cyc == last_rd + 1 || cyc == last_rd + 2) chk("gap_request", scrub_request, 0);
                exp_wr = scrub_request && wr_pend;
                chk("scrub_write", scrub_write, exp_wr);
                chk("write_block", scrub_write_block, exp_wr ? wr_data : 13'h0);
                if (scrub_request) chk("scrub_address", scrub_address, wr_pend ? wr_addr : m_addr);
                if (scrub_request && scrub_grant) begin
                    if (wr_pend) begin
                        wr_pend = 0;
                        advance(cyc + 1);
                    end else begin
                        n_reads++;
                        rd_cyc.push_back(cyc);
                        last_rd = cyc;
                        decode(mem[m_addr], kind, fixed);
                        if (kind != 0) begin
                            ev_due = cyc + 3; ev_unc = (kind == 2); ev_addr = m_addr;
                            inc_due = cyc + 3; inc_unc = (kind == 2);
                        end
                        if (kind == 1 && WB) begin
                            wr_pend = 1; wr_addr = m_addr; wr_data = fixed;
                        end else begin
                            advance(cyc + 3);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int n, kind, r0, a0, bad;
        logic [12:0] fixed, orig5, orig7;
        reset = 1'b1; enable = 1'b0; start = 1'b0; clear_counters = 1'b0; scrub_grant = 1'b1;
        scrub_read_block = '0;
        fork
            monitor();
            memory();
        join_none
        for (int i = 0; i < DEPTH; i++) mem[i] = enc(8'(i * 17 + 3));

        // literal pins on the model
        chk("enc_01", enc(8'h01), 13'h1007);
        chk("enc_80", enc(8'h80), 13'h1888);
        decode(13'h1007 ^ 13'h0008, kind, fixed);
        chk("dec_single_kind", kind, 1);
        chk("dec_single_fix", fixed, 13'h1007);
        decode(13'h1007 ^ 13'h0041, kind, fixed);
        chk("dec_double_kind", kind, 2);

        repeat (3) @(posedge clock);
        #1;
        chk("rst_address", scrub_address, 0);
        chk("rst_error_valid", error_valid, 0);
        chk("rst_error_address", error_address, 0);
        chk("rst_pass_done", pass_done, 0);
        chk("rst_counts", {corrected_count, uncorrectable_count}, 0);

        // phase 1: clean memory, grant always high
        reset = 1'b0; enable = 1'b1;
        n = 0;
        while (!scrub_request && n < 20) begin @(posedge clock); #1; n++; end
        chk("first_request_delay", n, INTERVAL);
        n = 0;
        while (n_reads < DEPTH + 2 && n < 400) begin @(posedge clock); #1; n++; end
        chk("phase1_wait", n < 400, 1);
        bad = 0;
        for (int i = 1; i < rd_cyc.size(); i++)
            if (bad == 0 && rd_cyc[i] - rd_cyc[i-1] != 7) bad = rd_cyc[i] - rd_cyc[i-1];
        chk("read_cadence_7", bad, 0);
        chk("pass_done_once", n_pass_done, 1);

        // phase 2: single flip at 5, double flip at 7
        orig5 = mem[5]; orig7 = mem[7];
        mem[5] = orig5 ^ 13'h0008;
        mem[7] = orig7 ^ 13'h0041;
        ev_log_addr.delete(); ev_log_unc.delete();
        n = 0;
        while (ev_log_addr.size() < 2 && n < 400) begin @(posedge clock); #1; n++; end
        chk("phase2_wait", n < 400, 1);
        if (ev_log_addr.size() >= 2) begin
            chk("ev0_addr", ev_log_addr[0], 5);
            chk("ev0_unc", ev_log_unc[0], 0);
            chk("ev1_addr", ev_log_addr[1], 7);
            chk("ev1_unc", ev_log_unc[1], 1);
        end
        chk("p2_corrected", corrected_count, 1);
        chk("p2_uncorrectable", uncorrectable_count, 1);
        chk("p2_last_error_addr", error_address, 7);
        chk("p2_mem5", mem[5], WB ? orig5 : (orig5 ^ 13'h0008));
        mem[5] = orig5; mem[7] = orig7;

        // phase 3: grant withheld for 10 cycles
        n = 0;
        while (busy && n < 20) begin @(posedge clock); #1; n++; end
        scrub_grant = 1'b0;
        n = 0;
        while (!scrub_request && n < 20) begin @(posedge clock); #1; n++; end
        chk("p3_request_seen", scrub_request, 1);
        r0 = n_reads; a0 = int'(scrub_address);
        for (int i = 0; i < 10; i++) begin
            chk("hold_stable", {scrub_request, scrub_write, scrub_address}, {1'b1, 1'b0, 4'(a0)});
            @(posedge clock); #1;
        end
        chk("hold_no_read", n_reads, r0);
        scrub_grant = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("hold_one_read", n_reads, r0 + 1);
        chk("hold_back_idle", busy, 0);

        // phase 4: disabled, then a start pulse
        enable = 1'b0;
        r0 = n_reads;
        repeat (20) @(posedge clock);
        #1;
        chk("disabled_no_read", n_reads, r0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("start_request", scrub_request, 1);
        repeat (3) @(posedge clock);
        #1;
        chk("start_back_idle", busy, 0);
        repeat (20) @(posedge clock);
        #1;
        chk("start_single_read", n_reads, r0 + 1);

        // phase 5: saturation and clear priority
        clear_counters = 1'b1;
        @(posedge clock); #1;
        clear_counters = 1'b0;
        chk("cleared", {corrected_count, uncorrectable_count}, 0);
        for (int i = 0; i < DEPTH; i++) mem[i] = enc(8'(i * 17 + 3)) ^ (13'(1) << (i % 13));
        enable = 1'b1;
        n = 0;
        while (corrected_count != 4'(CMAX) && n < 600) begin @(posedge clock); #1; n++; end
        chk("sat_reached", corrected_count, CMAX);
        r0 = n_reads;
        n = 0;
        while (n_reads < r0 + 2 && n < 100) begin @(posedge clock); #1; n++; end
        repeat (4) @(posedge clock);
        #1;
        chk("sat_hold", corrected_count, CMAX);
        enable = 1'b0;
        n = 0;
        while (busy && n < 20) begin @(posedge clock); #1; n++; end
        for (int i = 0; i < DEPTH; i++) mem[i] = enc(8'(i * 17 + 3)) ^ (13'(1) << (i % 13));
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        clear_counters = 1'b1;
        @(posedge clock); #1;
        clear_counters = 1'b0;
        chk("clear_coincident_ev", error_valid, 1);
        chk("clear_priority", corrected_count, 0);

        // phase 6: reset in the middle of an access
        n = 0;
        while (busy && n < 20) begin @(posedge clock); #1; n++; end
        mem[3] = enc(8'h5A) ^ 13'h0010;
        mem[4] = enc(8'h5A) ^ 13'h0010;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!(scrub_request && (scrub_write || !WB)) && n < 10) begin @(posedge clock); #1; n++; end
        chk("p6_access_seen", scrub_request, 1);
        reset = 1'b1;
        #1;
        chk("p6_request_drop", scrub_request, 0);
        chk("p6_busy", busy, 0);
        chk("p6_address", scrub_address, 0);
        chk("p6_counts", {corrected_count, uncorrectable_count}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/extended_hamming_scrubber.md
Name: extended_hamming_scrubber

Overview:
- Background scrub controller for a memory that stores extended Hamming protected blocks.
- Periodically reads each address through a shared request/grant memory port. Corrects each block with an internal extended_hamming_block_corrector and re-checks the result with an extended_hamming_block_checker.
- Writes corrected blocks back and reports corrected and uncorrectable events.
- Sits beside the functional memory arbiter as one of its requesters.

Parameters:
- BLOCK_WIDTH, 13, width of one stored block (8 data bits + 5 parity bits).
- DEPTH, 256, number of memory addresses; ADDRESS_WIDTH = $clog2(DEPTH).
- INTERVAL, 1024, idle cycles between two scrub reads (>= 1).
- COUNTER_WIDTH, 16, width of the status counters.

Ports:
- clock  input  1  clock, rising edge
- reset  input  1  asynchronous active-high reset
- enable  input  1  allow periodic scrubbing
- start  input  1  pulse; skip the remaining interval and scrub the next address immediately
- clear_counters  input  1  pulse; zero both counters
- scrub_request  output  1  memory access request
- scrub_grant  input  1  arbiter grant; an access completes in a cycle with request & grant
- scrub_write  output  1  1 = write, 0 = read; stable while scrub_request is high
- scrub_address  output  ADDRESS_WIDTH  access address
- scrub_write_block  output  BLOCK_WIDTH  write data
- scrub_read_block  input  BLOCK_WIDTH  read data, valid exactly 1 cycle after a granted read
- busy  output  1  state != IDLE
- error_valid  output  1  pulse; error found at error_address
- error_uncorrectable  output  1  qualifies error_valid
- error_address  output  ADDRESS_WIDTH  address of the last error
- pass_done  output  1  pulse when the address wraps from DEPTH-1 to 0
- corrected_count  output  COUNTER_WIDTH  saturating count of corrected blocks
- uncorrectable_count  output  COUNTER_WIDTH  saturating count of uncorrectable blocks

Behaviour:
- Reset: all outputs 0, address 0, interval counter = INTERVAL-1, state IDLE. Reset mid-access drops the request immediately.
- Interval counter: decrements in IDLE while enable=1, holds while enable=0. When it reaches 0, or on a start pulse in IDLE (start works regardless of enable), go to READ_REQ and reload INTERVAL-1.
- READ_REQ:
  - scrub_request=1, scrub_write=0, scrub_address=current address.
  - Held until grant; on grant go to READ_WAIT.
- READ_WAIT: capture scrub_read_block into the block register; go to CHECK.
- CHECK: corrector and re-checker are combinational on the block register.
  - Corrector error=0: advance the address, go to IDLE.
  - error=1 and re-check clean:
    - error_valid=1, error_uncorrectable=0, error_address updated, corrected_count++.
    - Go to WRITE_REQ with scrub_write_block = corrected block.
  - error=1 and re-check fails: error_valid=1, error_uncorrectable=1, uncorrectable_count++, no write; advance the address, go to IDLE.
- WRITE_REQ: scrub_request=1, scrub_write=1, held until grant; then advance the address, go to IDLE.
- Clean block with immediate grant: request asserted 1 cycle after the interval expires; back in IDLE 3 cycles after the request is first asserted.
- Address advance: wraps DEPTH-1 → 0, pulsing pass_done the same cycle.
- enable deasserted mid-scrub: the current address completes; no new scrub starts.
- start outside IDLE: ignored.
- Counters: saturate at all-ones. clear_counters takes priority over a simultaneous increment (result 0).
- No combinational path from scrub_grant to scrub_request.

Optional Feature:
- EXTENDED_HAMMING_SCRUBBER_WRITEBACK_EN defined: correctable errors are written back via WRITE_REQ as above.
- Undefined: report-only. WRITE_REQ is never entered, scrub_write is tied 0, scrub_write_block is tied 0, and corrected_count still increments.

Test Plan:
- INTERVAL=4, enable=1, clean memory, grant always 1 → one read every 7 cycles (4 idle + 3 active), address 0,1,2…; pass_done pulses after address DEPTH-1 → 0; counters stay 0.
- Address 5 holds a valid block with bit 3 flipped, writeback enabled → error_valid=1, error_uncorrectable=0, error_address=5, corrected_count=1, then a granted write of the original block to address 5.
- Address 7 holds a block with bits 0 and 6 flipped → error_valid=1, error_uncorrectable=1, uncorrectable_count=1, no write request.
- Grant withheld 10 cycles in READ_REQ → request, address and write=0 stable for all 10 cycles; exactly one read completes.
- enable=0, then a start pulse → one address scrubbed immediately, then IDLE; reset asserted during WRITE_REQ → request drops the same cycle, counters and address return to 0.
- corrected_count at 16'hFFFF plus another corrected error → stays 16'hFFFF; clear_counters coincident with an increment → 0.
